// File: rtl/snn_pkg.sv
// Shared defaults, derived widths and arithmetic helpers for the spiking WTA layer.
package snn_pkg;

    localparam int unsigned INPUTS_DEF  = 25;
    localparam int unsigned NEURONS_DEF = 2;
    localparam int unsigned WBITS_DEF   = 2;
    localparam int unsigned VBITS_DEF   = 8;
    localparam int unsigned THRESH_DEF  = 20;
    localparam int unsigned LEAK_DEF    = 1;
    localparam int unsigned REFRACT_DEF = 0;

    // Width of a counter able to hold 0..n; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    localparam int unsigned SUM_W = WBITS_DEF + $clog2(INPUTS_DEF + 1);
    localparam int unsigned RC_W  = cnt_w(REFRACT_DEF);

    // a + b clamped to max.
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

    // a - b floored at zero.
    function automatic int unsigned floor_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : 0;
    endfunction

endpackage

// File: rtl/snn_neuron_acc.sv
// One integrate-and-fire membrane: weighted input sum, saturating add, leak and clear.
module snn_neuron_acc
    import snn_pkg::*;
#(
    parameter int unsigned INPUTS = INPUTS_DEF,
    parameter int unsigned WBITS  = WBITS_DEF,
    parameter int unsigned VBITS  = VBITS_DEF,
    parameter int unsigned LEAK   = LEAK_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INPUTS*WBITS-1:0]   w_i,
    input  logic [INPUTS-1:0]         spikes_i,
    input  logic                      en_i,
    input  logic                      clr_i,
    output logic [VBITS-1:0]          v_next_o
);

    localparam int unsigned SumW = WBITS + $clog2(INPUTS + 1);
    localparam int unsigned VMax = (32'd1 << VBITS) - 32'd1;

    logic [SumW-1:0]  sum;
    logic [VBITS-1:0] v_q, v_d;
    int unsigned      t_sat, t_leak;

    // Sum of weights on active input lines.
    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(INPUTS); i++) begin
            if (spikes_i[i]) begin
                sum = sum + SumW'(w_i[i*WBITS +: WBITS]);
            end
        end
    end

    // Candidate membrane: saturate at the top of the range, then leak towards zero.
    always_comb begin
        t_sat    = sat_add(32'(v_q), 32'(sum), VMax);
        t_leak   = floor_sub(t_sat, LEAK);
        v_next_o = t_leak[VBITS-1:0];
    end

    // Clear wins over integration; otherwise hold.
    always_comb begin
        v_d = v_q;
        if (clr_i) begin
            v_d = '0;
        end else if (en_i) begin
            v_d = v_next_o;
        end
    end

    // Membrane register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

endmodule

// File: rtl/snn_wta_layer.sv
// Integrate-and-fire output layer with winner-take-all lateral inhibition.
module snn_wta_layer
    import snn_pkg::*;
#(
    parameter int unsigned INPUTS  = INPUTS_DEF,
    parameter int unsigned NEURONS = NEURONS_DEF,
    parameter int unsigned WBITS   = WBITS_DEF,
    parameter int unsigned VBITS   = VBITS_DEF,
    parameter int unsigned THRESH  = THRESH_DEF,
    parameter int unsigned LEAK    = LEAK_DEF,
    parameter int unsigned REFRACT = REFRACT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(NEURONS)-1:0] wr_neuron,
    input  logic [$clog2(INPUTS)-1:0]  wr_input,
    input  logic [WBITS-1:0]           wr_data,
    input  logic                       in_valid,
    input  logic [INPUTS-1:0]          spikes_in,
    input  logic                       inhibit,
    output logic [NEURONS-1:0]         spike_out,
    output logic                       spike_valid,
    output logic [$clog2(NEURONS)-1:0] winner,
    output logic                       refractory
);

    localparam int unsigned NW  = $clog2(NEURONS);
    localparam int unsigned RcW = cnt_w(REFRACT);

    logic [WBITS-1:0]        w_q [NEURONS][INPUTS];
    logic [INPUTS*WBITS-1:0] w_flat [NEURONS];
    logic [VBITS-1:0]        v_next [NEURONS];

    logic [VBITS-1:0]   best_v;
    logic [NW-1:0]      best_idx;
    logic               refr_active, integ, fire, clr;
    logic [RcW-1:0]     rc_q, rc_d;
    logic [NEURONS-1:0] spike_out_q, spike_out_d;
    logic               spike_valid_q;
    logic [NW-1:0]      winner_q, winner_d;

    // Weight store; indices beyond the array are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < int'(NEURONS); n++) begin
                for (int i = 0; i < int'(INPUTS); i++) begin
                    w_q[n][i] <= '0;
                end
            end
        end else if (wr_en && (32'(wr_neuron) < NEURONS) && (32'(wr_input) < INPUTS)) begin
            w_q[wr_neuron][wr_input] <= wr_data;
        end
    end

    // Flatten each neuron's weight row for its accumulator.
    always_comb begin
        for (int n = 0; n < int'(NEURONS); n++) begin
            w_flat[n] = '0;
            for (int i = 0; i < int'(INPUTS); i++) begin
                w_flat[n][i*WBITS +: WBITS] = w_q[n][i];
            end
        end
    end

    for (genvar n = 0; n < int'(NEURONS); n++) begin : g_neuron
        snn_neuron_acc #(
            .INPUTS (INPUTS),
            .WBITS  (WBITS),
            .VBITS  (VBITS),
            .LEAK   (LEAK)
        ) u_acc (
            .clk      (clk),
            .rst      (rst),
            .w_i      (w_flat[n]),
            .spikes_i (spikes_in),
            .en_i     (integ),
            .clr_i    (clr),
            .v_next_o (v_next[n])
        );
    end

    // Argmax over candidate membranes; strict compare keeps the lowest index on ties.
    always_comb begin
        best_v   = v_next[0];
        best_idx = '0;
        for (int n = 1; n < int'(NEURONS); n++) begin
            if (v_next[n] > best_v) begin
                best_v   = v_next[n];
                best_idx = NW'(n);
            end
        end
    end

    // Step control: inhibit beats refractory beats integration.
    always_comb begin
        refr_active = (rc_q != '0);
        integ       = in_valid && !inhibit && !refr_active;
        fire        = integ && (32'(best_v) >= THRESH);
        // A refractory step leaves membranes at zero, which they already are after a spike.
        clr         = inhibit || fire || (in_valid && refr_active);
    end

    // Next-state for refractory counter and output registers.
    always_comb begin
        rc_d = rc_q;
        if (fire) begin
            rc_d = RcW'(REFRACT);
        end else if (in_valid && !inhibit && refr_active) begin
            rc_d = rc_q - 1'b1;
        end
        spike_out_d           = '0;
        spike_out_d[best_idx] = fire;
        winner_d              = fire ? best_idx : winner_q;
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q          <= '0;
            spike_out_q   <= '0;
            spike_valid_q <= 1'b0;
            winner_q      <= '0;
        end else begin
            rc_q          <= rc_d;
            spike_out_q   <= spike_out_d;
            spike_valid_q <= in_valid;
            winner_q      <= winner_d;
        end
    end

    assign spike_out   = spike_out_q;
    assign spike_valid = spike_valid_q;
    assign winner      = winner_q;
    assign refractory  = (rc_q != '0);

endmodule

// File: tb/tb_snn_wta_layer.sv
// Directed-vector bench for snn_wta_layer: default, refractory and saturation configurations.
module tb_snn_wta_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [0:0]  wr_neuron;
    logic [4:0]  wr_input;
    logic [1:0]  wr_data;
    logic        in_valid;
    logic [24:0] spikes_in;
    logic        inhibit;

    logic [1:0] a_spike, b_spike, c_spike;
    logic       a_valid, b_valid, c_valid;
    logic [0:0] a_win, b_win, c_win;
    logic       a_refr, b_refr, c_refr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    snn_wta_layer u_dut_a (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_neuron (wr_neuron),
        .wr_input (wr_input), .wr_data (wr_data), .in_valid (in_valid),
        .spikes_in (spikes_in), .inhibit (inhibit), .spike_out (a_spike),
        .spike_valid (a_valid), .winner (a_win), .refractory (a_refr)
    );

    snn_wta_layer #(.REFRACT (2)) u_dut_b (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_neuron (wr_neuron),
        .wr_input (wr_input), .wr_data (wr_data), .in_valid (in_valid),
        .spikes_in (spikes_in), .inhibit (inhibit), .spike_out (b_spike),
        .spike_valid (b_valid), .winner (b_win), .refractory (b_refr)
    );

    snn_wta_layer #(.THRESH (255)) u_dut_c (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_neuron (wr_neuron),
        .wr_input (wr_input), .wr_data (wr_data), .in_valid (in_valid),
        .spikes_in (spikes_in), .inhibit (inhibit), .spike_out (c_spike),
        .spike_valid (c_valid), .winner (c_win), .refractory (c_refr)
    );

    logic [7:0] a_v0, a_v1, b_v0, c_v0;
    assign a_v0 = u_dut_a.g_neuron[0].u_acc.v_q;
    assign a_v1 = u_dut_a.g_neuron[1].u_acc.v_q;
    assign b_v0 = u_dut_b.g_neuron[0].u_acc.v_q;
    assign c_v0 = u_dut_c.g_neuron[0].u_acc.v_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_neuron = '0;
        wr_input  = '0;
        wr_data   = '0;
        in_valid  = 1'b0;
        spikes_in = '0;
        inhibit   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic wr(input int n, input int i, input int d);
        wr_en     = 1'b1;
        wr_neuron = 1'(n);
        wr_input  = 5'(i);
        wr_data   = 2'(d);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic step(input logic [24:0] vec, input logic inh);
        in_valid  = 1'b1;
        spikes_in = vec;
        inhibit   = inh;
        cyc();
        in_valid  = 1'b0;
        spikes_in = '0;
        inhibit   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        #2;
        do_reset();

        // Reset state
        check("rst_spike", a_spike, 0);
        check("rst_valid", a_valid, 0);
        check("rst_winner", a_win, 0);
        check("rst_refr", b_refr, 0);
        check("rst_v0", a_v0, 0);

        // Threshold crossing: w[0][0..4]=3
        for (int i = 0; i < 5; i++) wr(0, i, 3);
        step(25'h1F, 1'b0);
        check("cross1_v0", a_v0, 14);
        check("cross1_spike", a_spike, 0);
        check("cross1_valid", a_valid, 1);
        step(25'h1F, 1'b0);
        check("cross2_spike", a_spike, 2'b01);
        check("cross2_winner", a_win, 0);
        check("cross2_valid", a_valid, 1);
        check("cross2_v0", a_v0, 0);
        check("cross2_v1", a_v1, 0);
        check("cross2_noref", a_refr, 0);
        check("ref_spike", b_spike, 2'b01);
        check("ref_rise", b_refr, 1);

        // Refractory (REFRACT=2)
        step(25'h1F, 1'b0);
        check("ref1_spike", b_spike, 0);
        check("ref1_v0", b_v0, 0);
        check("ref1_refr", b_refr, 1);
        check("ref1_valid", b_valid, 1);
        step(25'h1F, 1'b0);
        check("ref2_spike", b_spike, 0);
        check("ref2_v0", b_v0, 0);
        check("ref2_refr", b_refr, 0);
        step(25'h1F, 1'b0);
        check("ref3_v0", b_v0, 14);

        // Neuron 1 wins alone, then winner holds across a quiet step
        do_reset();
        for (int i = 0; i < 5; i++) wr(1, i, 3);
        step(25'h1F, 1'b0);
        step(25'h1F, 1'b0);
        check("n1_spike", a_spike, 2'b10);
        check("n1_winner", a_win, 1);
        step(25'h0, 1'b0);
        check("hold_spike", a_spike, 0);
        check("hold_winner", a_win, 1);

        // Tie-break: identical weights, lowest index wins
        for (int i = 0; i < 5; i++) wr(0, i, 3);
        step(25'h1F, 1'b0);
        check("tie1_v1", a_v1, 14);
        step(25'h1F, 1'b0);
        check("tie_spike", a_spike, 2'b01);
        check("tie_winner", a_win, 0);

        // Inhibit together with a spike-causing step
        step(25'h1F, 1'b0);
        check("inh_pre_v0", a_v0, 14);
        step(25'h1F, 1'b1);
        check("inh_spike", a_spike, 0);
        check("inh_valid", a_valid, 1);
        check("inh_v0", a_v0, 0);
        check("inh_v1", a_v1, 0);

        // in_valid=0 holds membranes with no leak
        step(25'h1F, 1'b0);
        cyc();
        check("idle_v0", a_v0, 14);
        check("idle_valid", a_valid, 0);

        // Mid-run reset with a discarded in_valid
        rst       = 1'b1;
        in_valid  = 1'b1;
        spikes_in = 25'h1F;
        cyc();
        idle_inputs();
        check("mrst_valid", a_valid, 0);
        check("mrst_v0", a_v0, 0);
        step(25'h1F, 1'b0);
        step(25'h1F, 1'b0);
        check("mrst_spike", a_spike, 0);
        check("mrst_winner", a_win, 0);
        check("mrst_v0b", a_v0, 0);

        // Write in the same cycle as in_valid uses the old weight
        wr_en     = 1'b1;
        wr_neuron = 1'b0;
        wr_input  = 5'd0;
        wr_data   = 2'd3;
        in_valid  = 1'b1;
        spikes_in = 25'h1;
        cyc();
        idle_inputs();
        check("wrv_v0", a_v0, 0);
        step(25'h1, 1'b0);
        check("wrv_next_v0", a_v0, 2);

        // Saturation (THRESH=255): 74, 148, 222, 254, 254
        do_reset();
        for (int i = 0; i < 25; i++) wr(0, i, 3);
        step(25'h1FFFFFF, 1'b0);
        check("sat1", c_v0, 74);
        step(25'h1FFFFFF, 1'b0);
        check("sat2", c_v0, 148);
        step(25'h1FFFFFF, 1'b0);
        check("sat3", c_v0, 222);
        step(25'h1FFFFFF, 1'b0);
        check("sat4", c_v0, 254);
        step(25'h1FFFFFF, 1'b0);
        check("sat5", c_v0, 254);
        check("sat_spike", c_spike, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snn_wta_layer.md
# snn_wta_layer

Synthesizable spiking output layer of integrate-and-fire neurons with a shared winner-take-all lateral-inhibition network. It generalises the two-neuron, 2-bit-weight test network to NEURONS output neurons, WBITS-bit weights, configurable leak and refractory period, and a runtime weight-write port. It sits between the input spike encoder, which delivers one spike vector per timestep, and the classification readout.

## Interface
- INPUTS, 25, input spike lines per timestep
- NEURONS, 2, output neurons (≥2)
- WBITS, 2, unsigned weight width per synapse
- VBITS, 8, unsigned membrane potential width
- THRESH, 20, firing threshold (≤ 2^VBITS−1)
- LEAK, 1, amount subtracted from each membrane per integrated timestep
- REFRACT, 0, timesteps ignored after a spike (0 = none)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  weight write strobe
- wr_neuron  in  $clog2(NEURONS)  target neuron
- wr_input  in  $clog2(INPUTS)  target synapse
- wr_data  in  WBITS  weight value
- in_valid  in  1  spikes_in holds one timestep
- spikes_in  in  INPUTS  input spike vector
- inhibit  in  1  external inhibit; clears all membranes
- spike_out  out  NEURONS  one-hot winner spike, 1-cycle pulse
- spike_valid  out  1  result of a timestep is valid
- winner  out  $clog2(NEURONS)  index of last spiking neuron
- refractory  out  1  refractory counter nonzero

## Operation
- Weight store: NEURONS×INPUTS×WBITS registers, all 0 at reset. When wr_en is high, write the word at (wr_neuron, wr_input). Out-of-range indices are ignored.
- Per timestep (in_valid=1, inhibit=0, refractory=0), for each neuron n:
  - sum_n = Σ w[n][i] over active inputs; width WBITS+$clog2(INPUTS+1).
  - t = min(v_n + sum_n, 2^VBITS−1).
  - v_n' = t − LEAK, floored at 0.
- Fire: if any v_n' ≥ THRESH, the winner is the neuron with the largest v_n'. Ties go to the lowest index.
  - spike_out = one-hot(winner); winner register updated.
  - All membranes are cleared to 0 (lateral inhibition).
  - The refractory counter is loaded with REFRACT.
- If no neuron fires, the membranes take v_n', spike_out = 0, and winner holds its value.
- While refractory: an in_valid step decrements the counter, membranes stay 0, spike_out = 0, and spike_valid = 1.
- inhibit=1: all membranes are cleared and no spike is produced. spike_valid follows in_valid. The refractory counter is unaffected.
- Priority: rst > inhibit > refractory > integrate.

## Timing
- Reset values: spike_out=0, spike_valid=0, winner=0, refractory=0, all membranes=0, all weights=0.
- Latency: 1 cycle. Outputs for the timestep presented at edge k appear after edge k and hold for one cycle only.
- in_valid may be asserted every cycle (throughput 1 timestep/cycle). With in_valid=0, the block holds state and applies no leak.
- Write and in_valid in the same cycle: integration uses the pre-write weights. The new weight is used from the next cycle.
- rst asserted mid-run clears membranes, weights and counters at the next edge. An in_valid in the same cycle is discarded.
- Spike and refractory load happen at the same edge. refractory rises with spike_out when REFRACT>0.

## Structure
- Package snn_pkg:
  - Widths: SUM_W = WBITS+$clog2(INPUTS+1), RC_W = $clog2(REFRACT+1).
  - sat_add and floor_sub functions.
- Sub-module snn_neuron_acc, one instance per neuron: weighted sum, saturating membrane register, leak, and a clear input.
- The top level holds the weight store, argmax/tie-break tree, refractory counter and output registers.

## Test plan
- Threshold crossing: after reset, write w[0][0..4]=3 with other weights 0. THRESH=20, LEAK=1. Drive inputs 0–4 high on two steps → step 1: v0=14, no spike; step 2: v0 reaches 28, so spike_out=2'b01, winner=0, spike_valid=1, and all membranes are 0 afterwards.
- Tie-break: give both neurons identical weights and drive the same steps → spike_out=2'b01, winner=0.
- Refractory: REFRACT=2, repeat the crossing stimulus → the 2 steps after the spike give spike_out=0, membranes 0, refractory=1. The 3rd step integrates, giving v0=14.
- Saturation: all weights 3, all 25 inputs high, THRESH=255, LEAK=1 → v0 goes 74, 148, 222, 254, then stays at 254 with no spike.
- Inhibit: assert inhibit together with a spike-causing in_valid → no spike, spike_valid=1, membranes 0.
- Mid-run reset: pulse rst after v0=14, then repeat the crossing stimulus → weights are 0, no spike, outputs 0.
